// File: rtl/fu_pkg.sv
// fu_pkg: shared writeback widths, flag indices and buffer entry type
package fu_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int FLG_Z = 3;
  localparam int FLG_C = 2;
  localparam int FLG_N = 1;
  localparam int FLG_V = 0;
  typedef struct packed {
    logic [DATA_W-1:0] f;
    logic [3:0]        zcnv;
    logic [ADDR_W-1:0] da;
    logic              wr;
    logic              fl;
  } wb_entry_t;
  // R0 is hardwired, so writes to it never reach the register file
  function automatic logic rf_wr_en(wb_entry_t e);
    return e.wr && (e.da != '0);
  endfunction
endpackage

// File: rtl/fu_writeback_stage_if.sv
// fu_writeback_stage_if: function-unit input, register-file output and status/forwarding bus
interface fu_writeback_stage_if;
  logic                      IN_VALID;
  logic                      IN_READY;
  logic [fu_pkg::DATA_W-1:0] F_IN;
  logic [3:0]                ZCNV_IN;
  logic [fu_pkg::ADDR_W-1:0] DA_IN;
  logic                      WR_IN;
  logic                      FL_IN;
  logic                      OUT_READY;
  logic                      RF_WR;
  logic [fu_pkg::ADDR_W-1:0] RF_DA;
  logic [fu_pkg::DATA_W-1:0] RF_D;
  logic [3:0]                STATUS;
  logic [1:0]                COUNT;
  logic                      FWD_VALID;
  logic [fu_pkg::ADDR_W-1:0] FWD_DA;
  logic [fu_pkg::DATA_W-1:0] FWD_D;
  modport master (
    output IN_VALID, F_IN, ZCNV_IN, DA_IN, WR_IN, FL_IN, OUT_READY,
    input  IN_READY, RF_WR, RF_DA, RF_D, STATUS, COUNT, FWD_VALID, FWD_DA, FWD_D
  );
  modport slave (
    input  IN_VALID, F_IN, ZCNV_IN, DA_IN, WR_IN, FL_IN, OUT_READY,
    output IN_READY, RF_WR, RF_DA, RF_D, STATUS, COUNT, FWD_VALID, FWD_DA, FWD_D
  );
endinterface

// File: rtl/fu_writeback_stage_wb_fifo2.sv
// wb_fifo2: two-entry FIFO of writeback entries; tail port exists only with FU_WB_FWD_EN
module wb_fifo2
  import fu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic       pop_i,
  input  wb_entry_t  din_i,
  output wb_entry_t  head_o,
`ifdef FU_WB_FWD_EN
  output wb_entry_t  tail_o,
`endif
  output logic [1:0] count_o
);
  logic       do_push, do_pop;
  logic       wr_q, rd_q;
  logic [1:0] count_q, count_d;
  wb_entry_t  mem_q [2];
  // overflow and underflow requests are dropped here so count never leaves 0..2
  always_comb begin
    do_push = push_i && (count_q != 2'd2);
    do_pop  = pop_i && (count_q != 2'd0);
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end
  // pointers and occupancy, 1-bit pointers wrap modulo 2
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      count_q <= 2'd0;
    end else begin
      wr_q    <= wr_q ^ do_push;
      rd_q    <= rd_q ^ do_pop;
      count_q <= count_d;
    end
  end
  // storage needs no reset: contents are only observed through count
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
  assign head_o  = mem_q[rd_q];
`ifdef FU_WB_FWD_EN
  assign tail_o  = mem_q[~rd_q];
`endif
  assign count_o = count_q;
endmodule

// File: rtl/fu_writeback_stage.sv
// fu_writeback_stage: skid-buffered writeback to the register file and status commit; forwarding via FU_WB_FWD_EN
module fu_writeback_stage
  import fu_pkg::*;
(
  input logic                 CLK,
  input logic                 RESET,
  fu_writeback_stage_if.slave bus
);
  logic       live, hv, push, pop;
  logic [1:0] count;
  logic [3:0] status_q, status_d;
  wb_entry_t  din, head;
`ifdef FU_WB_FWD_EN
  wb_entry_t  tail;
  logic       tail_ok, head_ok;
`endif
  // handshake and status next-state; everything observable is blanked while RESET is high
  always_comb begin
    live     = !RESET;
    hv       = count != 2'd0;
    din      = '{f: bus.F_IN, zcnv: bus.ZCNV_IN, da: bus.DA_IN, wr: bus.WR_IN, fl: bus.FL_IN};
    push     = bus.IN_VALID && bus.IN_READY;
    pop      = live && hv && bus.OUT_READY;
    status_d = (pop && head.fl) ? {head.zcnv[FLG_Z], head.zcnv[FLG_C], head.zcnv[FLG_N], head.zcnv[FLG_V]} : status_q;
  end
  wb_fifo2 u_fifo (
    .clk     (CLK),
    .rst     (RESET),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (din),
    .head_o  (head),
`ifdef FU_WB_FWD_EN
    .tail_o  (tail),
`endif
    .count_o (count)
  );
  // architectural status register, committed as flag-setting entries retire
  always_ff @(posedge CLK) begin
    if (RESET) status_q <= 4'b0000;
    else       status_q <= status_d;
  end
  // register-file port shows the head entry, zeroed when empty or in reset
  always_comb begin
    bus.IN_READY = live && (count != 2'd2);
    bus.COUNT    = live ? count : 2'd0;
    bus.STATUS   = live ? status_q : 4'b0000;
    bus.RF_WR    = live && hv && rf_wr_en(head);
    bus.RF_DA    = (live && hv) ? head.da : '0;
    bus.RF_D     = (live && hv) ? head.f : '0;
  end
`ifdef FU_WB_FWD_EN
  // youngest pending register write wins; the tail is only valid when full
  always_comb begin
    tail_ok       = live && (count == 2'd2) && rf_wr_en(tail);
    head_ok       = live && hv && rf_wr_en(head);
    bus.FWD_VALID = tail_ok || head_ok;
    bus.FWD_DA    = tail_ok ? tail.da : head_ok ? head.da : '0;
    bus.FWD_D     = tail_ok ? tail.f : head_ok ? head.f : '0;
  end
`else
  // forwarding disabled: ports kept for a uniform interface
  always_comb begin
    bus.FWD_VALID = 1'b0;
    bus.FWD_DA    = '0;
    bus.FWD_D     = '0;
  end
`endif
endmodule

// File: tb/tb_fu_writeback_stage.sv
// tb_fu_writeback_stage: directed vector table plus a streaming sequence for fu_writeback_stage
module tb_fu_writeback_stage;
  typedef struct {
    logic        rst, iv, wr, fl, ordy;
    logic [31:0] f;
    logic [3:0]  z;
    logic [4:0]  da;
    logic        e_ir, e_rfwr, e_fv;
    logic [4:0]  e_rda, e_fda;
    logic [31:0] e_rd, e_fd;
    logic [3:0]  e_st;
    logic [1:0]  e_cnt;
  } vec_t;
  logic clk, rst;
  int total, bad;
  vec_t v [$];
  fu_writeback_stage_if bus ();
  fu_writeback_stage dut (.CLK(clk), .RESET(rst), .bus(bus));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  function automatic void add(int r, int iv, int f, int z, int da, int wr, int fl, int ordy,
                              int ir, int rfwr, int rda, int rd, int st, int cnt, int fv, int fda, int fd);
    vec_t e;
    e.rst = 1'(r); e.iv = 1'(iv); e.f = 32'(f); e.z = 4'(z); e.da = 5'(da);
    e.wr = 1'(wr); e.fl = 1'(fl); e.ordy = 1'(ordy);
    e.e_ir = 1'(ir); e.e_rfwr = 1'(rfwr); e.e_rda = 5'(rda); e.e_rd = 32'(rd);
    e.e_st = 4'(st); e.e_cnt = 2'(cnt);
`ifdef FU_WB_FWD_EN
    e.e_fv = 1'(fv); e.e_fda = 5'(fda); e.e_fd = 32'(fd);
`else
    e.e_fv = 1'b0; e.e_fda = 5'(fda & 0); e.e_fd = 32'(fd & 0);
`endif
    v.push_back(e);
  endfunction
  task automatic chk(string n, int i, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", n, i, a, e);
    end
  endtask
  task automatic drive(logic r, logic iv, logic [31:0] f, logic [3:0] z, logic [4:0] da, logic wr, logic fl, logic ordy);
    rst = r; bus.IN_VALID = iv; bus.F_IN = f; bus.ZCNV_IN = z; bus.DA_IN = da;
    bus.WR_IN = wr; bus.FL_IN = fl; bus.OUT_READY = ordy;
  endtask
  initial begin
    total = 0; bad = 0;
    add(1,1,9,15,1,1,1,1,      0,0,0,0,0,0,      0,0,0);
    add(1,1,9,15,1,1,1,1,      0,0,0,0,0,0,      0,0,0);
    add(0,0,0,0,0,0,0,1,       1,0,0,0,0,0,      0,0,0);
    add(0,1,5,0,3,1,1,1,       1,0,0,0,0,0,      0,0,0);
    add(0,1,0,8,4,1,1,1,       1,1,3,5,0,1,      1,3,5);
    add(0,0,0,0,0,0,0,1,       1,1,4,0,0,1,      1,4,0);
    add(0,0,0,0,0,0,0,0,       1,0,0,0,8,0,      0,0,0);
    add(0,1,'h11,0,5,1,0,0,    1,0,0,0,8,0,      0,0,0);
    add(0,1,'h22,0,6,1,0,0,    1,1,5,'h11,8,1,   1,5,'h11);
    add(0,1,'h33,0,7,1,0,0,    0,1,5,'h11,8,2,   1,6,'h22);
    add(0,1,'h33,0,7,1,0,1,    0,1,5,'h11,8,2,   1,6,'h22);
    add(0,1,'h33,0,7,1,0,1,    1,1,6,'h22,8,1,   1,6,'h22);
    add(0,0,0,0,0,0,0,1,       1,1,7,'h33,8,1,   1,7,'h33);
    add(0,1,'h44,6,0,1,1,1,    1,0,0,0,8,0,      0,0,0);
    add(0,0,0,0,0,0,0,1,       1,0,0,'h44,8,1,   0,0,0);
    add(0,1,1,1,1,0,1,1,       1,0,0,0,6,0,      0,0,0);
    add(0,1,2,15,2,0,0,1,      1,0,1,1,6,1,      0,0,0);
    add(0,0,0,0,0,0,0,1,       1,0,2,2,1,1,      0,0,0);
    add(0,0,0,0,0,0,0,0,       1,0,0,0,1,0,      0,0,0);
    add(0,1,'hA,0,7,1,0,0,     1,0,0,0,1,0,      0,0,0);
    add(0,1,'hB,0,7,1,0,0,     1,1,7,'hA,1,1,    1,7,'hA);
    add(0,1,'hC,0,9,1,0,0,     0,1,7,'hA,1,2,    1,7,'hB);
    add(1,1,'hC,0,9,1,0,1,     0,0,0,0,0,0,      0,0,0);
    add(0,0,0,0,0,0,0,1,       1,0,0,0,0,0,      0,0,0);
    foreach (v[i]) begin
      drive(v[i].rst, v[i].iv, v[i].f, v[i].z, v[i].da, v[i].wr, v[i].fl, v[i].ordy);
      @(negedge clk);
      chk("in_ready", i, 32'(bus.IN_READY), 32'(v[i].e_ir));
      chk("rf_wr", i, 32'(bus.RF_WR), 32'(v[i].e_rfwr));
      chk("rf_da", i, 32'(bus.RF_DA), 32'(v[i].e_rda));
      chk("rf_d", i, bus.RF_D, v[i].e_rd);
      chk("status", i, 32'(bus.STATUS), 32'(v[i].e_st));
      chk("count", i, 32'(bus.COUNT), 32'(v[i].e_cnt));
      chk("fwd_valid", i, 32'(bus.FWD_VALID), 32'(v[i].e_fv));
      chk("fwd_da", i, 32'(bus.FWD_DA), 32'(v[i].e_fda));
      chk("fwd_d", i, bus.FWD_D, v[i].e_fd);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'(i < 4), 32'h100 + 32'(i), 4'(i), 5'(i + 1), 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      if (i > 0) begin
        chk("stream_d", 100 + i, bus.RF_D, 32'h100 + 32'(i - 1));
        chk("stream_da", 100 + i, 32'(bus.RF_DA), 32'(i));
        chk("stream_wr", 100 + i, 32'(bus.RF_WR), 32'd1);
        chk("stream_cnt", 100 + i, 32'(bus.COUNT), 32'd1);
        chk("stream_rdy", 100 + i, 32'(bus.IN_READY), 32'd1);
      end
      @(posedge clk); #1;
    end
    drive(1'b0, 1'b0, 32'h0, 4'h0, 5'h0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("stream_end_cnt", 200, 32'(bus.COUNT), 32'd0);
    chk("stream_end_st", 200, 32'(bus.STATUS), 32'd3);
    chk("stream_end_wr", 200, 32'(bus.RF_WR), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
